// File: rtl/lenet_saver_pkg.sv
// lenet_saver_pkg: shared types, defaults and width helper for the feature-map savers
package lenet_saver_pkg;
    localparam int DEFAULT_DATA_W = 18;
    typedef enum logic {S_FILL, S_WAIT} state_t;
    typedef logic bank_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/layer_pingpong_saver_if.sv
// layer_pingpong_saver_if: sample stream, reader release and RAM write port of the saver
interface layer_pingpong_saver_if #(
    parameter int DATA_W = lenet_saver_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = 9
);
    logic signed [DATA_W-1:0] i_din;
    logic                     i_din_valid;
    logic                     o_din_ready;
    logic [1:0]               i_bank_release;
    logic signed [DATA_W-1:0] o_dout;
    logic [ADDR_W-1:0]        o_addr;
    logic                     o_we;
    logic                     o_save_finish;
    logic [1:0]               o_bank_full;
    logic                     o_wr_bank;
    modport master (
        input  i_din, i_din_valid, i_bank_release,
        output o_din_ready, o_dout, o_addr, o_we, o_save_finish, o_bank_full, o_wr_bank
    );
    modport slave (
        output i_din, i_din_valid, i_bank_release,
        input  o_din_ready, o_dout, o_addr, o_we, o_save_finish, o_bank_full, o_wr_bank
    );
endinterface

// File: rtl/saver_bank_tracker.sv
// saver_bank_tracker: per-bank full flags and the bank currently being filled
module saver_bank_tracker
    import lenet_saver_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame_done,
    input  logic [1:0] i_bank_release,
    output logic [1:0] o_bank_full,
    output bank_t      o_wr_bank
);
    logic [1:0] r_full;
    bank_t      r_wr_bank;
    assign o_bank_full = r_full;
    assign o_wr_bank   = r_wr_bank;
    // a frame completing on a bank wins over a same-cycle release of that bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
        end else begin
            r_full <= (r_full & ~i_bank_release) | (i_frame_done ? (2'b01 << r_wr_bank) : 2'b00);
            if (i_frame_done) r_wr_bank <= ~r_wr_bank;
        end
    end
endmodule

// File: rtl/layer_pingpong_saver.sv
// layer_pingpong_saver: writes sample frames alternately into two RAM banks.
// Define SAVER_RELU_EN to store negative samples as zero (fused ReLU).
module layer_pingpong_saver
    import lenet_saver_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    layer_pingpong_saver_if.master io_bus
);
    localparam int CW = ADDR_W - 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    state_t                   r_state;
    logic [CW-1:0]            r_count;
    logic signed [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_we;
    logic                     r_fin;
    logic                     w_ready, w_acc, w_last, w_busy;
    logic [1:0]               w_bank_full;
    bank_t                    w_wr_bank;
    logic signed [DATA_W-1:0] w_wdata;
    saver_bank_tracker u_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_frame_done   (w_last),
        .i_bank_release (io_bus.i_bank_release),
        .o_bank_full    (w_bank_full),
        .o_wr_bank      (w_wr_bank)
    );
`ifdef SAVER_RELU_EN
    assign w_wdata = io_bus.i_din[DATA_W-1] ? '0 : io_bus.i_din;
`else
    assign w_wdata = io_bus.i_din;
`endif
    assign w_ready = (r_state == S_FILL);
    assign w_acc   = io_bus.i_din_valid & w_ready;
    assign w_last  = w_acc & (r_count == LAST);
    // the next bank counts as busy only if it will still be full after this edge
    assign w_busy  = w_bank_full[~w_wr_bank] & ~io_bus.i_bank_release[~w_wr_bank];
    assign io_bus.o_din_ready   = w_ready;
    assign io_bus.o_dout        = r_dout;
    assign io_bus.o_addr        = r_addr;
    assign io_bus.o_we          = r_we;
    assign io_bus.o_save_finish = r_fin;
    assign io_bus.o_bank_full   = w_bank_full;
    assign io_bus.o_wr_bank     = w_wr_bank;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
            r_count <= '0;
            r_dout  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            r_we  <= w_acc;
            r_fin <= w_last;
            if (w_acc) begin
                r_dout  <= w_wdata;
                r_addr  <= {w_wr_bank, r_count};
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
            r_state <= (r_state == S_FILL) ? ((w_last && w_busy) ? S_WAIT : S_FILL)
                                           : (w_bank_full[w_wr_bank] ? S_WAIT : S_FILL);
        end
    end
endmodule

// File: tb/tb_layer_pingpong_saver.sv
// tb_layer_pingpong_saver: randomized self-checking bench against a frame/bank reference model
module tb_layer_pingpong_saver;
    localparam int DW    = 18;
    localparam int DEPTH = 256;
    localparam int AW    = 9;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    bit [1:0] m_full;
    bit       m_wr;
    int       m_cnt;
    bit       m_prevf;
    int       m_writes;
    int       m_fins;
    bit                e_we, e_fin;
    logic signed [DW-1:0] e_dout;
    int                e_addr;
    layer_pingpong_saver_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    layer_pingpong_saver #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic signed [DW-1:0] store(input logic signed [DW-1:0] d);
`ifdef SAVER_RELU_EN
        return (d < 0) ? '0 : d;
`else
        return d;
`endif
    endfunction
    task automatic model_reset();
        m_full = 2'b00; m_wr = 1'b0; m_cnt = 0; m_prevf = 1'b0;
        e_we = 1'b0; e_fin = 1'b0; e_dout = '0; e_addr = 0;
    endtask
    task automatic do_reset();
        bus.i_din_valid = 1'b0; bus.i_din = '0; bus.i_bank_release = 2'b00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_we", bus.o_we, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_dout", bus.o_dout, 0);
        chk("rst_fin", bus.o_save_finish, 0);
        chk("rst_full", bus.o_bank_full, 0);
        chk("rst_wrbank", bus.o_wr_bank, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask
    // one clock: drive inputs, predict the edge from the frame/bank rules, compare after it
    task automatic step(input bit v, input logic signed [DW-1:0] d, input bit [1:0] r);
        bit f, rdy, acc, fin;
        bit [1:0] nf;
        bus.i_din_valid = v; bus.i_din = d; bus.i_bank_release = r;
        f   = m_full[m_wr];
        rdy = !f && !m_prevf;
        chk("ready", bus.o_din_ready, rdy);
        acc = v && rdy;
        fin = acc && (m_cnt == DEPTH - 1);
        nf  = m_full & ~r;
        if (fin) nf[m_wr] = 1'b1;
        e_we = acc; e_fin = fin;
        if (acc) begin
            e_dout = store(d);
            e_addr = m_wr * DEPTH + m_cnt;
            m_writes++;
        end
        if (fin) m_fins++;
        m_prevf = f;
        if (fin) begin m_wr = !m_wr; m_cnt = 0; end
        else if (acc) m_cnt++;
        m_full = nf;
        @(posedge clk); #1;
        chk("we", bus.o_we, e_we);
        chk("save_finish", bus.o_save_finish, e_fin);
        chk("dout", bus.o_dout, e_dout);
        chk("addr", bus.o_addr, e_addr);
        chk("bank_full", bus.o_bank_full, m_full);
        chk("wr_bank", bus.o_wr_bank, m_wr);
    endtask
    initial begin
        int cyc, w0, f0;
        model_reset();
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 2'b00);
        chk("f1_full", bus.o_bank_full, 2'b01);
        chk("f1_wrbank", bus.o_wr_bank, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 2'b00);
        chk("f2_full", bus.o_bank_full, 2'b11);
        chk("f2_ready", bus.o_din_ready, 0);
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 2'b00);
        step(1'b0, '0, 2'b01);
        step(1'b0, '0, 2'b00);
        step(1'b0, '0, 2'b00);
        chk("rel_ready", bus.o_din_ready, 1);
        step(1'b1, DW'(-5), 2'b00);
        chk("relu_addr0", bus.o_addr, 0);
        step(1'b1, DW'(7), 2'b00);
        step(1'b1, DW'(-131072), 2'b00);
        do_reset();
        w0 = m_writes; f0 = m_fins; cyc = 0;
        while (m_writes - w0 < 3 * DEPTH && cyc < 5000) begin
            step($urandom_range(0, 9) >= 3, DW'($urandom),
                 {m_full[1] && $urandom_range(0, 1) == 1, m_full[0] && $urandom_range(0, 1) == 1});
            cyc++;
        end
        chk("rand_writes", m_writes - w0, 3 * DEPTH);
        chk("rand_fins", m_fins - f0, 3);
        cyc = 0;
        while (m_cnt < 100 && cyc < 2000) begin
            step(1'b1, DW'($urandom), m_full);
            cyc++;
        end
        chk("mid_wrbank", bus.o_wr_bank, 1);
        chk("mid_addr", bus.o_addr, DEPTH + 99);
        do_reset();
        step(1'b1, DW'(123), 2'b00);
        chk("post_rst_addr", bus.o_addr, 0);
        chk("post_rst_full", bus.o_bank_full, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
